// File: rtl/gb_mul_arb.sv
// rtl/gb_mul_arb.sv - two-requester round-robin arbiter and 2-stage pipeline around the shared gb_mul multiply
module gb_mul_arb #(
   parameter int TAG_W = 4
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [1:0]       i_req_valid,
   output logic [1:0]       o_req_ready,
   input  logic [63:0]      i_req0_op1,
   input  logic [63:0]      i_req0_op2,
   input  logic [1:0]       i_req0_mhdr,
   input  logic [1:0]       i_req0_op_signed,
   input  logic [TAG_W-1:0] i_req0_tag,
   input  logic [63:0]      i_req1_op1,
   input  logic [63:0]      i_req1_op2,
   input  logic [1:0]       i_req1_mhdr,
   input  logic [1:0]       i_req1_op_signed,
   input  logic [TAG_W-1:0] i_req1_tag,
   input  logic             i_flush,
   output logic             o_rsp_valid,
   input  logic             i_rsp_ready,
   output logic             o_rsp_id,
   output logic [TAG_W-1:0] o_rsp_tag,
   output logic [63:0]      o_rsp_res
);

   localparam logic [1:0] LPIP_OP_MUL  = 2'd0;
   localparam logic [1:0] LPIP_OP_MULH = 2'd1;

   logic             rr;
   logic             s1_v;
   logic [63:0]      s1_op1;
   logic [63:0]      s1_op2;
   logic [1:0]       s1_mhdr;
   logic [1:0]       s1_sgn;
   logic             s1_id;
   logic [TAG_W-1:0] s1_tag;

   logic             s2_v;
   logic             s2_id;
   logic [TAG_W-1:0] s2_tag;
   logic [63:0]      s2_res;

   logic             s2_load;
   logic             accept;
   logic             win0;
   logic             win1;
   logic             grant0;
   logic             grant1;
   logic             grant;

   logic [63:0]      mag1;
   logic [63:0]      mag2;
   logic             neg;
   logic [127:0]     prod;
   logic [127:0]     prod_s;
   logic [63:0]      mul_res;

   always_comb begin
      s2_load = !s2_v | i_rsp_ready;
      accept  = !s1_v | s2_load;
      win0    = i_req_valid[0] & (!rr | !i_req_valid[1]);
      win1    = i_req_valid[1] & !win0;
      // reset and flush both suppress any grant so nothing enters a pipe being cleared
      grant0  = accept & win0 & !i_flush & !i_rst;
      grant1  = accept & win1 & !i_flush & !i_rst;
      grant   = grant0 | grant1;
   end

   assign o_req_ready = {grant1, grant0};

   // sign-magnitude multiply matching gb_mul: negate signed negatives, fix sign of product
   always_comb begin
      mag1    = (s1_sgn[1] & s1_op1[63]) ? (~s1_op1 + 64'd1) : s1_op1;
      mag2    = (s1_sgn[0] & s1_op2[63]) ? (~s1_op2 + 64'd1) : s1_op2;
      neg     = (s1_sgn[1] & s1_op1[63]) ^ (s1_sgn[0] & s1_op2[63]);
      prod    = {64'd0, mag1} * {64'd0, mag2};
      prod_s  = neg ? (~prod + 128'd1) : prod;
      case (s1_mhdr)
         LPIP_OP_MUL:  mul_res = prod_s[63:0];
         LPIP_OP_MULH: mul_res = prod_s[127:64];
         default:      mul_res = prod_s[63:0];
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rr <= 1'b0;
      end else if (grant) begin
         rr <= !grant1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush) begin
         s1_v <= 1'b0;
      end else if (accept) begin
         s1_v <= grant;
      end
      if (grant) begin
         s1_id   <= grant1;
         s1_op1  <= grant1 ? i_req1_op1       : i_req0_op1;
         s1_op2  <= grant1 ? i_req1_op2       : i_req0_op2;
         s1_mhdr <= grant1 ? i_req1_mhdr      : i_req0_mhdr;
         s1_sgn  <= grant1 ? i_req1_op_signed : i_req0_op_signed;
         s1_tag  <= grant1 ? i_req1_tag       : i_req0_tag;
      end
   end

   // S2 data is reset so the response port reads zero out of reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         s2_v   <= 1'b0;
         s2_id  <= 1'b0;
         s2_tag <= '0;
         s2_res <= '0;
      end else begin
         if (i_flush) begin
            s2_v <= 1'b0;
         end else if (s2_load) begin
            s2_v <= s1_v;
         end
         if (!i_flush && s2_load && s1_v) begin
            s2_id  <= s1_id;
            s2_tag <= s1_tag;
            s2_res <= mul_res;
         end
      end
   end

   assign o_rsp_valid = s2_v;
   assign o_rsp_id    = s2_id;
   assign o_rsp_tag   = s2_tag;
   assign o_rsp_res   = s2_res;

endmodule

// File: tb/tb_gb_mul_arb.sv
// tb/tb_gb_mul_arb.sv - directed self-checking bench for gb_mul_arb
module tb_gb_mul_arb;

   localparam logic [1:0] MUL  = 2'd0;
   localparam logic [1:0] MULH = 2'd1;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [63:0] r0_op1, r0_op2, r1_op1, r1_op2;
   logic [1:0]  r0_mhdr, r1_mhdr, r0_sgn, r1_sgn;
   logic [3:0]  r0_tag, r1_tag;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic        rsp_id;
   logic [3:0]  rsp_tag;
   logic [63:0] rsp_res;

   int n_cmp = 0;
   int n_err = 0;
   int n_acc;

   always #5 clk = ~clk;

   gb_mul_arb #(.TAG_W(4)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid), .o_req_ready(req_ready),
      .i_req0_op1(r0_op1), .i_req0_op2(r0_op2), .i_req0_mhdr(r0_mhdr),
      .i_req0_op_signed(r0_sgn), .i_req0_tag(r0_tag),
      .i_req1_op1(r1_op1), .i_req1_op2(r1_op2), .i_req1_mhdr(r1_mhdr),
      .i_req1_op_signed(r1_sgn), .i_req1_tag(r1_tag),
      .i_flush(flush),
      .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
      .o_rsp_id(rsp_id), .o_rsp_tag(rsp_tag), .o_rsp_res(rsp_res)
   );

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", name, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk_rsp(input string name, input logic id, input logic [3:0] tag, input logic [63:0] res);
      chk({name, "_valid"}, {63'd0, rsp_valid}, 64'd1);
      chk({name, "_id"}, {63'd0, rsp_id}, {63'd0, id});
      chk({name, "_tag"}, {60'd0, rsp_tag}, {60'd0, tag});
      chk({name, "_res"}, rsp_res, res);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; rsp_ready = 1'b1; req_valid = 2'b11;
      r0_op1 = '0; r0_op2 = '0; r1_op1 = '0; r1_op2 = '0;
      r0_mhdr = MUL; r1_mhdr = MUL; r0_sgn = 2'b00; r1_sgn = 2'b00;
      r0_tag = '0; r1_tag = '0;
      tick(); tick();
      settle();
      chk("reset_ready", {62'd0, req_ready}, 64'd0);
      chk("reset_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("reset_rsp_id", {63'd0, rsp_id}, 64'd0);
      chk("reset_rsp_tag", {60'd0, rsp_tag}, 64'd0);
      chk("reset_rsp_res", rsp_res, 64'd0);
      req_valid = 2'b00; rst = 1'b0;
      tick();

      // single unsigned MUL from requester 0
      req_valid = 2'b01; r0_op1 = 64'd3; r0_op2 = 64'd5; r0_mhdr = MUL; r0_sgn = 2'b00; r0_tag = 4'hA;
      settle();
      chk("single_ready", {62'd0, req_ready}, 64'd1);
      tick();
      req_valid = 2'b00;
      chk("single_c1_valid", {63'd0, rsp_valid}, 64'd0);
      tick();
      chk_rsp("single_c2", 1'b0, 4'hA, 64'd15);
      tick();
      chk("single_c3_valid", {63'd0, rsp_valid}, 64'd0);

      // signed MULH from requester 1, then the same operands unsigned
      req_valid = 2'b10; r1_op1 = 64'hFFFF_FFFF_FFFF_FFFF; r1_op2 = 64'd1; r1_mhdr = MULH; r1_sgn = 2'b11; r1_tag = 4'h5;
      settle();
      chk("mulh_s_ready", {62'd0, req_ready}, 64'd2);
      tick();
      req_valid = 2'b00;
      tick();
      chk_rsp("mulh_signed", 1'b1, 4'h5, 64'hFFFF_FFFF_FFFF_FFFF);
      tick();
      req_valid = 2'b10; r1_sgn = 2'b00; r1_tag = 4'h6;
      tick();
      req_valid = 2'b00;
      tick();
      chk_rsp("mulh_unsigned", 1'b1, 4'h6, 64'd0);
      tick();

      // round-robin with both requesters valid straight after reset
      rst = 1'b1; tick(); rst = 1'b0;
      r0_mhdr = MUL; r1_mhdr = MUL; r0_sgn = 2'b00; r1_sgn = 2'b00;
      for (int c = 0; c < 9; c++) begin
         if (c < 6) begin
            req_valid = 2'b11;
            r0_tag = 4'(c); r1_tag = 4'(8 + c);
            r0_op1 = 64'(c + 1); r0_op2 = 64'd2;
            r1_op1 = 64'(c + 1); r1_op2 = 64'd3;
         end else begin
            req_valid = 2'b00;
         end
         settle();
         if (c < 6) chk($sformatf("rr_ready_%0d", c), {62'd0, req_ready}, (c % 2 == 0) ? 64'd1 : 64'd2);
         if (c >= 2 && c < 8) begin
            if ((c - 2) % 2 == 0)
               chk_rsp($sformatf("rr_rsp_%0d", c - 2), 1'b0, 4'(c - 2), 64'((c - 1) * 2));
            else
               chk_rsp($sformatf("rr_rsp_%0d", c - 2), 1'b1, 4'(8 + c - 2), 64'((c - 1) * 3));
         end
         if (c == 8) chk("rr_drained", {63'd0, rsp_valid}, 64'd0);
         tick();
      end

      // back-pressure: req0 streams while the consumer stalls for 4 cycles
      n_acc = 0;
      rsp_ready = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req_valid = 2'b01; r0_op1 = 64'(10 + c); r0_op2 = 64'd1; r0_tag = 4'(c);
         settle();
         if (req_ready[0]) n_acc++;
         if (c >= 2) chk_rsp($sformatf("bp_stall_%0d", c), 1'b0, 4'd0, 64'd10);
         tick();
      end
      chk("bp_accepted", 64'(n_acc), 64'd2);
      req_valid = 2'b00; rsp_ready = 1'b1;
      settle();
      chk_rsp("bp_first", 1'b0, 4'd0, 64'd10);
      tick();
      chk_rsp("bp_second", 1'b0, 4'd1, 64'd11);
      tick();
      chk("bp_drained", {63'd0, rsp_valid}, 64'd0);

      // flush with S1 and S2 both full; pointer is 1 here
      rsp_ready = 1'b0;
      req_valid = 2'b01; r0_tag = 4'd3; tick();
      req_valid = 2'b01; r0_tag = 4'd4; tick();
      req_valid = 2'b11; flush = 1'b1; rsp_ready = 1'b1;
      settle();
      chk("flush_ready", {62'd0, req_ready}, 64'd0);
      chk("flush_rsp_valid_in", {63'd0, rsp_valid}, 64'd1);
      tick();
      flush = 1'b0; req_valid = 2'b00;
      chk("flush_rsp_valid_after", {63'd0, rsp_valid}, 64'd0);
      chk("flush_rr_held", {63'd0, dut.rr}, 64'd1);
      tick();
      chk("flush_s1_cleared", {63'd0, rsp_valid}, 64'd0);
      req_valid = 2'b11; r1_tag = 4'd7; r1_op1 = 64'd4; r1_op2 = 64'd4;
      settle();
      chk("flush_next_grant", {62'd0, req_ready}, 64'd2);
      tick();
      req_valid = 2'b00;
      tick();
      chk_rsp("flush_next_rsp", 1'b1, 4'd7, 64'd16);
      tick();

      // reset mid-stream with the pointer left at 1
      req_valid = 2'b11;
      tick(); tick(); tick();
      rst = 1'b1;
      settle();
      chk("rst_mid_ready", {62'd0, req_ready}, 64'd0);
      tick();
      chk("rst_mid_rsp_valid", {63'd0, rsp_valid}, 64'd0);
      chk("rst_mid_rr", {63'd0, dut.rr}, 64'd0);
      rst = 1'b0;
      settle();
      chk("rst_first_grant", {62'd0, req_ready}, 64'd1);
      tick();
      req_valid = 2'b00;
      tick(); tick(); tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/gb_mul_arb.md
# gb_mul_arb

Two-port arbiter and pipeline controller for the shared 64-bit multiplier (`gb_mul`). It accepts multiply requests from two independent requesters over valid/ready handshakes and grants one per cycle with round-robin priority. It registers operands, drives the combinational multiplier, and returns results with requester ID and tag through a single back-pressured response port. It sits between the integer issue ports and the single `gb_mul` instance.

## Interface
- `TAG_W`, default 4: width of the opaque per-request tag, returned unchanged.
- `i_clk` in 1: clock; all state updates on the rising edge.
- `i_rst` in 1: reset, synchronous and active-high.
- `i_req_valid` in 2: bit k means requester k presents a request.
- `o_req_ready` out 2: bit k means requester k's request is accepted this cycle; at most one bit is set.
- `i_req0_op1`, `i_req0_op2` / `i_req1_op1`, `i_req1_op2` in 64 each: operands per requester.
- `i_req0_mhdr`, `i_req1_mhdr` in 2: `LPIP_OP_MUL` selects the low 64 bits; `LPIP_OP_MULH` selects the high 64 bits.
- `i_req0_op_signed`, `i_req1_op_signed` in 2: bit1 means op1 is signed; bit0 means op2 is signed.
- `i_req0_tag`, `i_req1_tag` in TAG_W: opaque tag per requester.
- `i_flush` in 1: discard all in-flight requests.
- `o_rsp_valid` out 1: a result is presented.
- `i_rsp_ready` in 1: the consumer accepts the result.
- `o_rsp_id` out 1: the requester that issued this result.
- `o_rsp_tag` out TAG_W: tag of this result.
- `o_rsp_res` out 64: `gb_mul` result for the captured operands, mhdr and op_signed.

## Operation
- Two register stages:
  - S1 holds operands, mhdr, op_signed, id, tag and a valid bit.
  - The `gb_mul` instance is fed from S1.
  - S2 holds its result, id, tag and a valid bit. S2 drives the `o_rsp_*` outputs directly.
- Advance rules:
  - S2 loads from S1 when `!S2.v | i_rsp_ready`.
  - S1 can accept when `!S1.v | S2_load`. Call this `accept`.
- Arbitration uses the pointer `rr`, reset value 0:
  - Requester 0 wins when `i_req_valid[0] & (rr==0 | !i_req_valid[1])`.
  - Requester 1 wins otherwise, provided it is valid.
  - `o_req_ready[k] = accept & win_k & !i_flush`. Ready may depend on valid.
- On a grant to requester k, `rr <= ~k`. With no grant, `rr` holds.
  - With one requester valid, that requester streams at 1 result per cycle, as long as the response side is not stalled.
- Response handshake: the result transfers when `o_rsp_valid & i_rsp_ready`. While `o_rsp_valid & !i_rsp_ready`, all `o_rsp_*` outputs stay stable.
- Arithmetic follows `gb_mul` exactly:
  - Signed operands with the MSB set are negated before the multiply.
  - The product is negated when the two operand signs differ.
  - MULH returns bits [127:64]; any other mhdr returns bits [63:0].
- Flush: in the cycle `i_flush` is high:
  - S1.v and S2.v clear at the next edge.
  - No grant is made and `rr` holds.
  - `o_rsp_valid` may be high during the flush cycle. If it transfers in that cycle it counts as delivered; otherwise it is discarded.
- Reset at any point, including mid-operation: S1.v=0, S2.v=0, rr=0. Data registers are don't-care.

## Timing
- Reset values: `o_req_ready`=0 during `i_rst`, `o_rsp_valid`=0, `o_rsp_id`=0, `o_rsp_tag`=0, `o_rsp_res`=0.
- Latency: a request accepted at edge t gives `o_rsp_valid`=1 in the cycle after edge t+1, which is 2 cycles after acceptance.
- Throughput: 1 request per cycle while `i_rsp_ready`=1.
- Back-pressure:
  - With S2 stalled and S1 full, `o_req_ready`=0.
  - With S2 stalled and S1 empty, exactly one more request is accepted.
  - Maximum in-flight depth is 2.
- Simultaneous S2 drain and S1 fill in the same cycle is legal and loses no cycle.
- Results are returned in grant order. Results are never reordered or duplicated.

## Test plan
- Single multiply: req0 sends op1=3, op2=5, MUL, unsigned, tag=0xA at cycle 0, with `i_rsp_ready`=1. Required: `o_rsp_valid` at cycle 2 with res=15, id=0, tag=0xA; cycle 3 has `o_rsp_valid`=0.
- Signed MULH: req1 sends op1=0xFFFF_FFFF_FFFF_FFFF (−1), op2=1, op_signed=2'b11, MULH. Required: res=0xFFFF_FFFF_FFFF_FFFF and id=1. The same operands with op_signed=0 give res=0.
- Round-robin: both requesters valid continuously for 6 cycles after reset. Grants follow 0,1,0,1,0,1; the response id sequence matches and each tag matches its request.
- Back-pressure: `i_rsp_ready`=0 for 4 cycles while req0 streams. Required:
  - exactly 2 requests are accepted;
  - `o_rsp_*` stays stable;
  - after `i_rsp_ready`=1 both results appear in order on consecutive cycles.
- Flush: assert `i_flush` with S1 and S2 both valid. The next cycle has `o_rsp_valid`=0, no grant is made in the flush cycle, and `rr` is unchanged.
- Reset mid-stream: assert `i_rst` during full streaming. The next cycle has `o_rsp_valid`=0 and `rr`=0, and the first grant after release goes to requester 0 when both requesters are valid.
